// File: rtl/qed_pkg.sv
// rtl/qed_pkg.sv - shared types and classification helper for the QED commit tracker
package qed_pkg;

  typedef enum logic [1:0] {
    SIF_IDLE = 2'd0,
    SIF_ORIG = 2'd1,
    SIF_DONE = 2'd2,
    SIF_ERR  = 2'd3
  } sif_state_e;

  localparam int QED_CNT_WIDTH = 8;

  typedef logic [QED_CNT_WIDTH-1:0] qed_cnt_t;

  // Registers in the upper half of the file belong to the duplicate stream;
  // instructions without a destination rely on the duplicator's tag instead.
  function automatic logic qed_is_dup(input logic has_rd, input logic rd_upper, input logic tag);
    return has_rd ? rd_upper : tag;
  endfunction

endpackage

// File: rtl/qed_sat_counter.sv
// rtl/qed_sat_counter.sv - saturating commit counter with sticky saturation flag
module qed_sat_counter #(
  parameter int CNT_WIDTH = 8,
  parameter int INC_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 sat,
  output logic [CNT_WIDTH-1:0] cnt_next,
  output logic                 sat_next
);

  localparam int SUM_WIDTH = CNT_WIDTH + 1;

  logic [SUM_WIDTH-1:0] sum;

  // Next values are exported so the parent can register flags derived from them.
  always_comb begin
    sum      = {1'b0, cnt} + SUM_WIDTH'(inc);
    cnt_next = cnt;
    sat_next = sat;
    if (clear) begin
      cnt_next = '0;
      sat_next = 1'b0;
    end else if (sum[CNT_WIDTH]) begin
      cnt_next = '1;
      sat_next = 1'b1;
    end else begin
      cnt_next = sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_next;
      sat <= sat_next;
    end
  end

endmodule

// File: rtl/qed_commit_tracker.sv
// rtl/qed_commit_tracker.sv - counts original/duplicate retirements and runs the SIF check FSM
module qed_commit_tracker
  import qed_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int CNT_WIDTH       = QED_CNT_WIDTH,
  parameter int REG_ADDR_BITS   = 5
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     qed_en_i,
  input  logic                                     clear_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_has_rd_i,
  input  logic [NR_COMMIT_PORTS*REG_ADDR_BITS-1:0] commit_rd_i,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_dup_tag_i,
  output logic [CNT_WIDTH-1:0]                     qed_num_orig_o,
  output logic [CNT_WIDTH-1:0]                     qed_num_dup_o,
  output logic                                     qed_ready_o,
  output logic                                     qed_overflow_o,
  output logic                                     sif_commit_o,
  output logic [1:0]                               sif_state_o
);

  localparam int NW = $clog2(NR_COMMIT_PORTS + 1);
  localparam logic [NW-1:0] ONE = NW'(1);

  logic [NR_COMMIT_PORTS-1:0] retire;
  logic [NR_COMMIT_PORTS-1:0] is_dup;
  logic [NW-1:0]              n_orig;
  logic [NW-1:0]              n_dup;
  logic                       low_is_orig;

  always_comb begin
    n_orig      = '0;
    n_dup       = '0;
    low_is_orig = 1'b0;
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      logic [REG_ADDR_BITS-1:0] rd;
      rd        = commit_rd_i[p*REG_ADDR_BITS +: REG_ADDR_BITS];
      retire[p] = qed_en_i & commit_valid_i[p] & commit_ack_i[p];
      // x0 is never a duplicate destination even if the index layout changes.
      is_dup[p] = qed_is_dup(commit_has_rd_i[p],
                             rd[REG_ADDR_BITS-1] && (rd != '0),
                             commit_dup_tag_i[p]);
      if (retire[p]) begin
        if (is_dup[p]) n_dup  = n_dup + ONE;
        else           n_orig = n_orig + ONE;
      end
    end
    // Downward scan leaves the class of the lowest-index retiring port.
    for (int p = NR_COMMIT_PORTS - 1; p >= 0; p--) begin
      if (retire[p]) low_is_orig = !is_dup[p];
    end
  end

  logic [CNT_WIDTH-1:0] orig_next, dup_next;
  logic                 orig_sat, dup_sat, orig_sat_next, dup_sat_next;

  qed_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .INC_WIDTH (NW)
  ) u_orig_cnt (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clear    (clear_i),
    .inc      (n_orig),
    .cnt      (qed_num_orig_o),
    .sat      (orig_sat),
    .cnt_next (orig_next),
    .sat_next (orig_sat_next)
  );

  qed_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .INC_WIDTH (NW)
  ) u_dup_cnt (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clear    (clear_i),
    .inc      (n_dup),
    .cnt      (qed_num_dup_o),
    .sat      (dup_sat),
    .cnt_next (dup_next),
    .sat_next (dup_sat_next)
  );

  assign qed_overflow_o = orig_sat | dup_sat;

  logic ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (orig_next == dup_next) && (orig_next != '0) && !(orig_sat_next || dup_sat_next);
    end
  end

  assign qed_ready_o = ready_q;

  sif_state_e state_q, state_d;
  logic       commit_q, commit_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SIF_IDLE;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    commit_d = commit_q;
    if (clear_i) begin
      state_d  = SIF_IDLE;
      commit_d = 1'b0;
    end else begin
      unique case (state_q)
        SIF_IDLE: begin
          if (n_orig != '0 && n_dup == '0) begin
            state_d = SIF_ORIG;
          end else if (n_orig == ONE && n_dup == ONE && low_is_orig) begin
            state_d  = SIF_DONE;
            commit_d = 1'b1;
          end else if (n_dup != '0) begin
            state_d = SIF_ERR;
          end
        end
        SIF_ORIG: begin
          if (n_dup == ONE && n_orig == '0) begin
            state_d  = SIF_DONE;
            commit_d = 1'b1;
          end else if (n_orig != '0 || n_dup != '0) begin
            state_d = SIF_ERR;
          end
        end
        SIF_DONE: begin
          if (n_orig != '0 || n_dup != '0) state_d = SIF_ERR;
        end
        default: state_d = SIF_ERR;
      endcase
    end
  end

  assign sif_commit_o = commit_q;
  assign sif_state_o  = state_q;

endmodule

// File: tb/tb_qed_commit_tracker.sv
// tb/tb_qed_commit_tracker.sv - directed vector bench for qed_commit_tracker
module tb_qed_commit_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       qed_en_i;
  logic       clear_i;
  logic [1:0] commit_valid_i;
  logic [1:0] commit_ack_i;
  logic [1:0] commit_has_rd_i;
  logic [9:0] commit_rd_i;
  logic [1:0] commit_dup_tag_i;

  logic [7:0] orig8, dup8;
  logic       rdy8, ovf8, com8;
  logic [1:0] st8;
  logic [3:0] orig4, dup4;
  logic       rdy4, ovf4, com4;
  logic [1:0] st4;

  always #5 clk_i = ~clk_i;

  qed_commit_tracker #(.NR_COMMIT_PORTS(2), .CNT_WIDTH(8), .REG_ADDR_BITS(5)) u_dut8 (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .qed_en_i         (qed_en_i),
    .clear_i          (clear_i),
    .commit_valid_i   (commit_valid_i),
    .commit_ack_i     (commit_ack_i),
    .commit_has_rd_i  (commit_has_rd_i),
    .commit_rd_i      (commit_rd_i),
    .commit_dup_tag_i (commit_dup_tag_i),
    .qed_num_orig_o   (orig8),
    .qed_num_dup_o    (dup8),
    .qed_ready_o      (rdy8),
    .qed_overflow_o   (ovf8),
    .sif_commit_o     (com8),
    .sif_state_o      (st8)
  );

  qed_commit_tracker #(.NR_COMMIT_PORTS(2), .CNT_WIDTH(4), .REG_ADDR_BITS(5)) u_dut4 (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .qed_en_i         (qed_en_i),
    .clear_i          (clear_i),
    .commit_valid_i   (commit_valid_i),
    .commit_ack_i     (commit_ack_i),
    .commit_has_rd_i  (commit_has_rd_i),
    .commit_rd_i      (commit_rd_i),
    .commit_dup_tag_i (commit_dup_tag_i),
    .qed_num_orig_o   (orig4),
    .qed_num_dup_o    (dup4),
    .qed_ready_o      (rdy4),
    .qed_overflow_o   (ovf4),
    .sif_commit_o     (com4),
    .sif_state_o      (st4)
  );

  typedef struct {
    logic       en, clr;
    logic [1:0] vld, ack, hrd, tag;
    logic [4:0] rd1, rd0;
    logic [7:0] e_orig, e_dup;
    logic       e_rdy, e_ovf, e_com;
    logic [1:0] e_st;
  } vec_t;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs[19];

  function automatic vec_t mk(logic en, logic clr, logic [1:0] vld, logic [1:0] ack,
                              logic [1:0] hrd, logic [4:0] rd1, logic [4:0] rd0,
                              logic [1:0] tag, logic [7:0] e_orig, logic [7:0] e_dup,
                              logic e_rdy, logic e_ovf, logic e_com, logic [1:0] e_st);
    vec_t v;
    v.en = en; v.clr = clr; v.vld = vld; v.ack = ack; v.hrd = hrd; v.tag = tag;
    v.rd1 = rd1; v.rd0 = rd0;
    v.e_orig = e_orig; v.e_dup = e_dup; v.e_rdy = e_rdy; v.e_ovf = e_ovf;
    v.e_com = e_com; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic clr, input logic [1:0] vld,
                       input logic [1:0] ack, input logic [1:0] hrd, input logic [4:0] rd1,
                       input logic [4:0] rd0, input logic [1:0] tag);
    qed_en_i         = en;
    clear_i          = clr;
    commit_valid_i   = vld;
    commit_ack_i     = ack;
    commit_has_rd_i  = hrd;
    commit_rd_i      = {rd1, rd0};
    commit_dup_tag_i = tag;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] o, input logic [7:0] d,
                      input logic r, input logic ov, input logic c, input logic [1:0] s);
    chk({tag, "_orig"},   32'(orig8), 32'(o));
    chk({tag, "_dup"},    32'(dup8),  32'(d));
    chk({tag, "_ready"},  32'(rdy8),  32'(r));
    chk({tag, "_ovf"},    32'(ovf8),  32'(ov));
    chk({tag, "_commit"}, 32'(com8),  32'(c));
    chk({tag, "_state"},  32'(st8),   32'(s));
  endtask

  initial begin
    // en clr vld   ack   hrd   rd1 rd0 tag  | orig dup rdy ovf com st
    vecs[0]  = mk(1, 0, 2'b01, 2'b01, 2'b01,  0,  3, 2'b00, 1, 0, 0, 0, 0, 1);
    vecs[1]  = mk(1, 0, 2'b01, 2'b01, 2'b01,  0, 19, 2'b00, 1, 1, 1, 0, 1, 2);
    vecs[2]  = mk(1, 1, 2'b00, 2'b00, 2'b00,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 2'b11, 2'b11, 2'b11, 21,  5, 2'b00, 1, 1, 1, 0, 1, 2);
    vecs[4]  = mk(1, 1, 2'b00, 2'b00, 2'b00,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 2'b11, 2'b11, 2'b11,  5, 21, 2'b00, 1, 1, 1, 0, 0, 3);
    vecs[6]  = mk(1, 1, 2'b00, 2'b00, 2'b00,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 2'b01, 2'b01, 2'b00,  0,  0, 2'b01, 0, 1, 0, 0, 0, 3);
    vecs[8]  = mk(1, 0, 2'b01, 2'b01, 2'b01,  0,  3, 2'b00, 1, 1, 1, 0, 0, 3);
    vecs[9]  = mk(1, 0, 2'b00, 2'b00, 2'b00,  0,  0, 2'b00, 1, 1, 1, 0, 0, 3);
    vecs[10] = mk(1, 0, 2'b11, 2'b00, 2'b11,  3,  3, 2'b00, 1, 1, 1, 0, 0, 3);
    vecs[11] = mk(1, 1, 2'b00, 2'b00, 2'b00,  0,  0, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 2'b11, 2'b11, 2'b01,  0,  0, 2'b00, 2, 0, 0, 0, 0, 1);
    vecs[13] = mk(1, 0, 2'b10, 2'b10, 2'b00,  0,  0, 2'b10, 2, 1, 0, 0, 1, 2);
    vecs[14] = mk(1, 1, 2'b11, 2'b11, 2'b11, 21,  5, 2'b00, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 0, 2'b01, 2'b01, 2'b01,  0,  3, 2'b00, 1, 0, 0, 0, 0, 1);
    vecs[16] = mk(0, 0, 2'b11, 2'b11, 2'b11,  3, 19, 2'b00, 1, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 2'b01, 2'b01, 2'b00,  0,  0, 2'b01, 1, 0, 0, 0, 0, 1);
    vecs[18] = mk(1, 0, 2'b01, 2'b01, 2'b01,  0, 19, 2'b00, 1, 1, 1, 0, 1, 2);

    rst_ni = 1'b0;
    drive(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    step();
    step();
    chk8("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_orig4", 32'(orig4), 0);
    chk("rst_state4", 32'(st4), 0);
    rst_ni = 1'b1;
    step();
    chk8("post_rst", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].vld, vecs[i].ack, vecs[i].hrd,
            vecs[i].rd1, vecs[i].rd0, vecs[i].tag);
      step();
      chk8($sformatf("v%0d", i), vecs[i].e_orig, vecs[i].e_dup, vecs[i].e_rdy,
           vecs[i].e_ovf, vecs[i].e_com, vecs[i].e_st);
    end

    // Saturation on the narrow instance: the 16th original overflows a 4-bit count.
    drive(1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    step();
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 2'b01, 2'b01, 2'b01, 0, 1, 2'b00);
      step();
    end
    chk("sat15_orig4", 32'(orig4), 15);
    chk("sat15_ovf4", 32'(ovf4), 0);
    step();
    chk("sat16_orig4", 32'(orig4), 15);
    chk("sat16_ovf4", 32'(ovf4), 1);
    chk("sat16_ready4", 32'(rdy4), 0);
    chk("sat16_orig8", 32'(orig8), 16);
    chk("sat16_ovf8", 32'(ovf8), 0);
    drive(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    step();
    chk("sat_hold_ovf4", 32'(ovf4), 1);
    drive(1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    step();
    chk("satclr_orig4", 32'(orig4), 0);
    chk("satclr_ovf4", 32'(ovf4), 0);
    chk("satclr_state4", 32'(st4), 0);

    // Asynchronous reset in the middle of a retire burst.
    drive(1, 0, 2'b11, 2'b11, 2'b11, 21, 5, 2'b00);
    step();
    step();
    step();
    chk("burst_orig8", 32'(orig8), 3);
    chk("burst_dup8", 32'(dup8), 3);
    chk("burst_state8", 32'(st8), 3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk8("async_rst", 0, 0, 0, 0, 0, 0);
    chk("async_rst_dup4", 32'(dup4), 0);
    step();
    chk8("rst_held", 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    drive(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    step();
    chk8("rst_release", 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
